// File: rtl/pipe_pkg.sv
// Shared pipeline constants: register-file geometry, producer latencies and
// the forward-select encoding used by the forwarding mux control.
package pipe_pkg;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;
  localparam int LOAD_LAT = 1;
  localparam int ALU_LAT  = 0;
  localparam int WAIT_W   = 2;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'd0,
    FWD_EM      = 2'd1,
    FWD_WB      = 2'd2
  } fwd_sel_e;
endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: a busy flag plus a countdown of cycles until the
// pending result becomes forwardable. Priority is flush > set > retire > count.
module sb_entry
  import pipe_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              set_i,
  input  logic [WAIT_W-1:0] set_wait_i,
  input  logic              retire_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic [WAIT_W-1:0] wait_o
);
  logic              busy_q, busy_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  always_comb begin
    busy_d = busy_q;
    wait_d = wait_q;
    if (flush_i) begin
      busy_d = 1'b0;
      wait_d = '0;
    end else if (set_i) begin
      // A new writer replaces whatever was pending, even a same-cycle retire.
      busy_d = 1'b1;
      wait_d = set_wait_i;
    end else if (retire_i) begin
      busy_d = 1'b0;
      wait_d = '0;
    end else if (busy_q && (wait_q != '0)) begin
      wait_d = wait_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q <= 1'b0;
      wait_q <= '0;
    end else begin
      busy_q <= busy_d;
      wait_q <= wait_d;
    end
  end

  assign busy_o = busy_q;
  assign wait_o = wait_q;
endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side register scoreboard: tracks in-flight writes, stalls issue while
// a source operand is not yet forwardable, and reports the pending set.
module reg_scoreboard
  import pipe_pkg::*;
#(
  parameter int NUM_REGS_P = NUM_REGS,
  parameter int ADDR_W_P   = ADDR_W,
  parameter int LOAD_LAT_P = LOAD_LAT,
  parameter int ALU_LAT_P  = ALU_LAT
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  issue_valid_i,
  input  logic [ADDR_W_P-1:0]   issue_rs_addr_i,
  input  logic                  issue_rs_used_i,
  input  logic [ADDR_W_P-1:0]   issue_rt_addr_i,
  input  logic                  issue_rt_used_i,
  input  logic [ADDR_W_P-1:0]   issue_dst_addr_i,
  input  logic                  issue_dst_we_i,
  input  logic                  issue_is_load_i,
  input  logic                  wb_valid_i,
  input  logic [ADDR_W_P-1:0]   wb_addr_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic [NUM_REGS_P-1:0] busy_vec_o,
  output logic [ADDR_W_P:0]     pending_cnt_o
);
  logic [NUM_REGS_P-1:0] busy;
  logic [WAIT_W-1:0]     wait_cnt [NUM_REGS_P];
  logic                  rs_hazard, rt_hazard, accept, set_dst;
  logic [WAIT_W-1:0]     set_wait;
  logic [ADDR_W_P:0]     pop;

  // Busy with zero wait is forwardable, so only a nonzero countdown blocks.
  assign rs_hazard = issue_rs_used_i && busy[issue_rs_addr_i] && (wait_cnt[issue_rs_addr_i] != '0);
  assign rt_hazard = issue_rt_used_i && busy[issue_rt_addr_i] && (wait_cnt[issue_rt_addr_i] != '0);
  assign stall_o   = issue_valid_i && !flush_i && (rs_hazard || rt_hazard);
  assign accept    = issue_valid_i && !stall_o && !flush_i;
  assign set_dst   = accept && issue_dst_we_i;
  assign set_wait  = issue_is_load_i ? WAIT_W'(LOAD_LAT_P) : WAIT_W'(ALU_LAT_P);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS_P; gi++) begin : g_entry
      sb_entry u_entry (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .set_i      (set_dst && (issue_dst_addr_i == ADDR_W_P'(gi))),
        .set_wait_i (set_wait),
        .retire_i   (wb_valid_i && (wb_addr_i == ADDR_W_P'(gi))),
        .flush_i    (flush_i),
        .busy_o     (busy[gi]),
        .wait_o     (wait_cnt[gi])
      );
    end
  endgenerate

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_REGS_P; i++) begin
      pop = pop + (ADDR_W_P + 1)'(busy[i]);
    end
  end

  assign busy_vec_o    = busy;
  assign pending_cnt_o = pop;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed and randomized checks of reg_scoreboard against an array-based
// model of the busy/countdown rules.
module tb_reg_scoreboard;
  localparam int LD = 1;
  localparam int AL = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iv = 0, rsu = 0, rtu = 0, we = 0, ld = 0, wbv = 0, fl = 0;
  logic [2:0] rs = 0, rt = 0, dst = 0, wba = 0;
  logic       stall_o;
  logic [7:0] busy_vec_o;
  logic [3:0] pending_cnt_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  int m_busy [8];
  int m_wait [8];

  always #5 clk = ~clk;

  reg_scoreboard #(.NUM_REGS_P(8), .ADDR_W_P(3), .LOAD_LAT_P(LD), .ALU_LAT_P(AL)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .issue_valid_i(iv), .issue_rs_addr_i(rs), .issue_rs_used_i(rsu),
    .issue_rt_addr_i(rt), .issue_rt_used_i(rtu),
    .issue_dst_addr_i(dst), .issue_dst_we_i(we), .issue_is_load_i(ld),
    .wb_valid_i(wbv), .wb_addr_i(wba), .flush_i(fl),
    .stall_o(stall_o), .busy_vec_o(busy_vec_o), .pending_cnt_o(pending_cnt_o)
  );

  function automatic bit m_stall();
    bit h;
    if (!iv || fl) return 1'b0;
    h = (rsu && m_busy[rs] != 0 && m_wait[rs] > 0) || (rtu && m_busy[rt] != 0 && m_wait[rt] > 0);
    return h;
  endfunction

  function automatic logic [7:0] m_vec();
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = (m_busy[i] != 0);
    return v;
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < 8; i++) c += m_busy[i];
    return c;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 8; i++) begin m_busy[i] = 0; m_wait[i] = 0; end
  endtask

  task automatic drive(input logic v, input logic [2:0] a_rs, input logic a_rsu,
                       input logic [2:0] a_rt, input logic a_rtu, input logic [2:0] a_dst,
                       input logic a_we, input logic a_ld, input logic a_wbv,
                       input logic [2:0] a_wba, input logic a_fl);
    iv = v; rs = a_rs; rsu = a_rsu; rt = a_rt; rtu = a_rtu; dst = a_dst;
    we = a_we; ld = a_ld; wbv = a_wbv; wba = a_wba; fl = a_fl;
  endtask

  // Advance one edge and apply the rules: countdown, then retire, then the
  // accepted write (newest writer wins), with flush clearing everything.
  task automatic tick();
    bit acc;
    @(posedge clk);
    acc = iv && !m_stall() && !fl;
    if (fl) m_clear();
    else begin
      for (int i = 0; i < 8; i++) if (m_busy[i] != 0 && m_wait[i] > 0) m_wait[i]--;
      if (wbv) begin m_busy[wba] = 0; m_wait[wba] = 0; end
      if (acc && we) begin m_busy[dst] = 1; m_wait[dst] = ld ? LD : AL; end
    end
    #1;
    $display("txn t=%0t iv=%b acc=%b dst=%0d we=%b ld=%b wb=%b/%0d fl=%b -> busy=%h cnt=%0d",
             $time, iv, acc, dst, we, ld, wbv, wba, fl, busy_vec_o, pending_cnt_o);
  endtask

  task automatic clean();
    drive(0,0,0,0,0,0,0,0,0,0,1); tick();
  endtask

  task automatic test_reset();
    #2;
    total_cnt++; if (busy_vec_o !== 8'h00) $display("FAIL reset_vec: got %h want 00", busy_vec_o); else pass_cnt++;
    total_cnt++; if (pending_cnt_o !== 4'd0) $display("FAIL reset_cnt: got %0d want 0", pending_cnt_o); else pass_cnt++;
    #8 rst_n = 1'b1;
    m_clear();
    @(posedge clk); #1;
    drive(1,0,0,0,0,2,1,1,0,0,0); tick();
    drive(1,0,0,0,0,5,1,1,0,0,0); tick();
    total_cnt++; if (busy_vec_o !== 8'h24) $display("FAIL reset_pre_vec: got %h want 24", busy_vec_o); else pass_cnt++;
    drive(1,5,1,0,0,0,0,0,0,0,0); #2;
    total_cnt++; if (stall_o !== 1'b1) $display("FAIL reset_pre_stall: got %b want 1", stall_o); else pass_cnt++;
    rst_n = 1'b0; #1;
    m_clear();
    total_cnt++; if (busy_vec_o !== 8'h00) $display("FAIL reset_async_vec: got %h want 00", busy_vec_o); else pass_cnt++;
    total_cnt++; if (pending_cnt_o !== 4'd0) $display("FAIL reset_async_cnt: got %0d want 0", pending_cnt_o); else pass_cnt++;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL reset_async_stall: got %b want 0", stall_o); else pass_cnt++;
    #1 rst_n = 1'b1;
    drive(1,5,1,0,0,1,1,1,0,0,0); #1;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL reset_first_issue_stall: got %b want 0", stall_o); else pass_cnt++;
    tick();
    total_cnt++; if (busy_vec_o !== 8'h02) $display("FAIL reset_first_issue_vec: got %h want 02", busy_vec_o); else pass_cnt++;
  endtask

  task automatic test_load_use();
    clean();
    drive(1,0,0,0,0,3,1,1,0,0,0); #4;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL lu_c0_stall: got %b want 0", stall_o); else pass_cnt++;
    tick();
    total_cnt++; if (busy_vec_o[3] !== 1'b1) $display("FAIL lu_c1_busy3: got %b want 1", busy_vec_o[3]); else pass_cnt++;
    drive(1,3,1,0,0,0,0,0,0,0,0); #4;
    total_cnt++; if (stall_o !== 1'b1) $display("FAIL lu_c1_stall: got %b want 1", stall_o); else pass_cnt++;
    tick(); #4;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL lu_c2_stall: got %b want 0", stall_o); else pass_cnt++;
    total_cnt++; if (busy_vec_o[3] !== 1'b1) $display("FAIL lu_c2_busy3: got %b want 1", busy_vec_o[3]); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    clean();
    drive(1,0,0,0,0,5,1,0,0,0,0); tick();
    drive(1,0,0,5,1,0,0,0,0,0,0); #4;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL alu_b2b_stall: got %b want 0", stall_o); else pass_cnt++;
    tick();
    drive(1,0,0,0,0,5,1,1,0,0,0); tick();
    drive(1,0,1,5,0,0,0,0,0,0,0); #2;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL rt_unused_stall: got %b want 0", stall_o); else pass_cnt++;
    rtu = 1'b1; #2;
    total_cnt++; if (stall_o !== 1'b1) $display("FAIL rt_used_stall: got %b want 1", stall_o); else pass_cnt++;
    tick();
  endtask

  task automatic test_collision();
    clean();
    drive(1,0,0,0,0,2,1,1,0,0,0); tick();
    drive(1,0,0,0,0,2,1,1,1,2,0); tick();
    total_cnt++; if (busy_vec_o[2] !== 1'b1) $display("FAIL coll_busy2: got %b want 1", busy_vec_o[2]); else pass_cnt++;
    drive(1,2,1,0,0,0,0,0,0,0,0); #4;
    total_cnt++; if (stall_o !== 1'b1) $display("FAIL coll_reader_stall: got %b want 1", stall_o); else pass_cnt++;
    tick(); #4;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL coll_reader_go: got %b want 0", stall_o); else pass_cnt++;
    tick();
  endtask

  task automatic test_waw_retire();
    clean();
    drive(1,0,0,0,0,6,1,1,0,0,0); tick();
    drive(1,0,0,0,0,6,1,0,0,0,0); tick();
    total_cnt++; if (pending_cnt_o !== 4'd1) $display("FAIL waw_cnt_before: got %0d want 1", pending_cnt_o); else pass_cnt++;
    drive(0,0,0,0,0,0,0,0,1,6,0); tick();
    total_cnt++; if (busy_vec_o[6] !== 1'b0) $display("FAIL waw_busy6: got %b want 0", busy_vec_o[6]); else pass_cnt++;
    total_cnt++; if (pending_cnt_o !== 4'd0) $display("FAIL waw_cnt_after: got %0d want 0", pending_cnt_o); else pass_cnt++;
  endtask

  task automatic test_flush();
    clean();
    drive(1,0,0,0,0,1,1,1,0,0,0); tick();
    drive(1,0,0,0,0,4,1,1,0,0,0); tick();
    drive(1,0,0,0,0,7,1,1,0,0,0); tick();
    total_cnt++; if (pending_cnt_o !== 4'd3) $display("FAIL flush_cnt_before: got %0d want 3", pending_cnt_o); else pass_cnt++;
    drive(1,7,1,0,0,0,1,1,0,0,1); #4;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL flush_stall: got %b want 0", stall_o); else pass_cnt++;
    tick();
    total_cnt++; if (busy_vec_o !== 8'h00) $display("FAIL flush_vec: got %h want 00", busy_vec_o); else pass_cnt++;
    total_cnt++; if (pending_cnt_o !== 4'd0) $display("FAIL flush_cnt: got %0d want 0", pending_cnt_o); else pass_cnt++;
  endtask

  task automatic test_random();
    clean();
    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(0,3) != 0, 3'($urandom_range(0,7)), 1'($urandom_range(0,1)),
            3'($urandom_range(0,7)), 1'($urandom_range(0,1)), 3'($urandom_range(0,7)),
            $urandom_range(0,3) != 0, 1'($urandom_range(0,1)), $urandom_range(0,2) == 0,
            3'($urandom_range(0,7)), $urandom_range(0,24) == 0);
      #4;
      total_cnt++; if (stall_o !== m_stall()) $display("FAIL rand_stall[%0d]: got %b want %b", n, stall_o, m_stall()); else pass_cnt++;
      tick();
      total_cnt++; if (busy_vec_o !== m_vec()) $display("FAIL rand_vec[%0d]: got %h want %h", n, busy_vec_o, m_vec()); else pass_cnt++;
      total_cnt++; if (pending_cnt_o !== 4'(m_cnt())) $display("FAIL rand_cnt[%0d]: got %0d want %0d", n, pending_cnt_o, m_cnt()); else pass_cnt++;
    end
  endtask

  initial begin
    m_clear();
    test_reset();
    test_load_use();
    test_back_to_back();
    test_collision();
    test_waw_retire();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Producer-side companion to the forwarding mux control.
- Records every in-flight register write at issue and counts down how many cycles remain until that result can be forwarded.
- Raises an issue-stage stall when an instruction's source operand cannot yet be forwarded, e.g. load-use.
- Clears each entry when the write retires at writeback; flushes everything on a pipeline flush.

Parameters:
- NUM_REGS, 8, number of architectural registers tracked; all entries are real registers, with no hardwired zero.
- ADDR_W, 3, register address width; must equal clog2(NUM_REGS).
- LOAD_LAT, 1, extra cycles before a load result is forwardable; range 0..3.
- ALU_LAT, 0, extra cycles before an ALU result is forwardable; range 0..3.

Ports:
- clk_i  in  1  clock, all state on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- issue_valid_i  in  1  an instruction is presented at issue this cycle.
- issue_rs_addr_i  in  ADDR_W  rs source address.
- issue_rs_used_i  in  1  rs is actually read.
- issue_rt_addr_i  in  ADDR_W  rt source address.
- issue_rt_used_i  in  1  rt is actually read.
- issue_dst_addr_i  in  ADDR_W  destination address.
- issue_dst_we_i  in  1  the instruction writes a register.
- issue_is_load_i  in  1  the destination is produced by a load.
- wb_valid_i  in  1  a register write retires this cycle.
- wb_addr_i  in  ADDR_W  address being retired.
- flush_i  in  1  synchronous flush of all pending state.
- stall_o  out  1  hold issue; the presented instruction is not accepted.
- busy_vec_o  out  NUM_REGS  per-register pending-write flags.
- pending_cnt_o  out  ADDR_W+1  number of set busy bits.

Behaviour:
- Per-register state: busy (1 bit) and wait counter (2 bits).
- Reset (asynchronous, rst_n_i=0):
  - all busy=0, all wait=0.
  - stall_o=0, busy_vec_o=0, pending_cnt_o=0.
  - Outputs hold these values for as long as reset is asserted; reset mid-operation discards all pending entries.
- stall_o is combinational and asserts when issue_valid_i=1 and either:
  - issue_rs_used_i=1 and busy[rs]=1 and wait[rs]!=0, or
  - issue_rt_used_i=1 and busy[rt]=1 and wait[rt]!=0.
  - stall_o=0 whenever issue_valid_i=0 or flush_i=1.
- Accept: issue_valid_i=1 and stall_o=0. On accept with issue_dst_we_i=1, at the next edge:
  - busy[dst]=1;
  - wait[dst]=LOAD_LAT if issue_is_load_i=1, else ALU_LAT.
  - If the destination is already busy, it is overwritten (WAW): the newest writer wins.
- Countdown: every cycle, each entry with busy=1 and wait>0 decrements wait by 1, saturating at 0. An entry written by an accept this cycle does not also decrement.
- Retire: wb_valid_i=1 clears busy[wb_addr_i] and sets its wait to 0.
- Same-cycle retire and accept to the same address: the accept wins; the entry takes the new busy and wait values.
- A retire to a register that is not busy has no effect.
- flush_i=1: at the next edge all busy and wait are 0; flush overrides accept and retire in the same cycle.
- Self-dependence: an instruction whose source equals its own destination is evaluated against the pre-accept state.
- Latency:
  - busy_vec_o and pending_cnt_o are registered views of the state, updated one edge after the causing event.
  - stall_o has zero latency.
- pending_cnt_o equals the popcount of busy; its range is 0..NUM_REGS, and width ADDR_W+1 holds NUM_REGS exactly.

Decomposition:
- Shared package pipe_pkg holds:
  - ADDR_W and NUM_REGS;
  - LOAD_LAT and ALU_LAT defaults;
  - the forward-select encoding constants, FWD_REGFILE=0, FWD_EM=1, FWD_WB=2, so they match the forwarding mux control.
- One sub-module is natural: sb_entry, one busy and wait slot with set, retire, flush and decrement priority logic. It is instantiated NUM_REGS times via generate.
- The top level contains address decode, the stall compare and the popcount.

Test Plan:
- Reset: hold rst_n_i=0 mid-traffic with busy_vec_o=8'h24 -> busy_vec_o=0, pending_cnt_o=0 and stall_o=0 immediately (asynchronous reset); after release, the first issue is accepted with no stall.
- Load-use: issue a load to r3 at cycle 0; at cycle 1 issue an instruction with rs=r3 used -> stall_o=1 for exactly 1 cycle (LOAD_LAT=1), accepted at cycle 2; busy_vec_o bit 3 = 1 from cycle 1.
- ALU back-to-back: an ALU op writes r5, and the next op reads rt=r5 -> no stall (ALU_LAT=0); an unused rt=r5 with a busy load also gives no stall.
- Retire/accept collision: r2 is busy; in the same cycle wb_addr_i=2 with wb_valid_i=1 and an accepted load to r2 -> busy[2]=1 with wait=1, and a subsequent reader of r2 stalls 1 cycle.
- WAW plus retire: issue a load to r6, then an ALU op to r6, then retire r6 once -> busy[6]=0 and pending_cnt_o decrements from 1 to 0.
- Flush: with r1, r4 and r7 busy, assert flush_i together with a load issue to r0 -> next cycle busy_vec_o=0, pending_cnt_o=0, and r0 is not marked.
